// File: rtl/midi_tx_encoder.sv
// ---------------------------------------------------------------------------
// midi_tx_encoder
//
// Outbound MIDI transmitter. Accepts control-change, pitch-bend and note
// events, formats each one into a 3-byte MIDI message and shifts it out 8N1
// (start bit, 8 data bits LSB first, stop bit) at the MIDI bit rate on
// midi_txd. Used to echo panel and controller values to a MIDI OUT jack.
//
// Optional feature (compile-time macro MIDI_RUNNING_STATUS_EN):
//   When defined, the status byte of a message is skipped if it equals the
//   last status byte sent, so the frame is 2 bytes instead of 3. Reset
//   clears the remembered status so the next message always carries one.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        MIDI bit rate
//   (BIT_CLKS = CLK_HZ/BAUD clocks per serial bit, derived, not overridable)
//
// Ports:
//   CLOCK_25    in   system clock, all logic on posedge
//   reset_data  in   synchronous active-high reset
//   ev_valid    in   event request, held stable until accepted
//   ev_ready    out  high only while idle; event taken on ev_valid && ev_ready
//   ev_type     in   0=control change, 1=pitch bend, 2=note on, 3=note off
//   ev_chan     in   MIDI channel 0..15
//   ev_d1       in   CC controller number / note key number
//   ev_d2       in   CC value / note velocity
//   pitch_val   in   14-bit pitch-bend value (8192 = centre)
//   midi_txd    out  serial MIDI line, idles high
//   busy        out  high from acceptance until the last stop bit completes
// ---------------------------------------------------------------------------
module midi_tx_encoder #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 31250
) (
  input  logic        CLOCK_25,
  input  logic        reset_data,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [1:0]  ev_type,
  input  logic [3:0]  ev_chan,
  input  logic [6:0]  ev_d1,
  input  logic [6:0]  ev_d2,
  input  logic [13:0] pitch_val,
  output logic        midi_txd,
  output logic        busy
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int TIMER_W  = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [1:0] EV_CC   = 2'd0;
  localparam logic [1:0] EV_PB   = 2'd1;
  localparam logic [1:0] EV_NON  = 2'd2;
  localparam logic [1:0] EV_NOFF = 2'd3;

  // Registered state
  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [2:0]           bit_idx;
  logic [1:0]           byte_idx;
  logic [7:0]           msg [3];

  // Next-state values
  state_t               state_n;
  logic [TIMER_W-1:0]   timer_n;
  logic [2:0]           bit_n;
  logic [1:0]           byte_n;
  logic                 busy_n;
  logic                 txd_n;
  logic                 load;
  logic                 bit_tick;
  logic [7:0]           cur_byte;

  // Formatted message for the event currently presented on the inputs
  logic [7:0]           status_byte;
  logic [7:0]           data1_byte;
  logic [7:0]           data2_byte;
  logic                 skip_status;

  assign ev_ready = (state == S_IDLE);
  assign load     = (state == S_IDLE) && ev_valid;
  assign bit_tick = (timer == TIMER_LAST);

  // -------------------------------------------------------------------------
  // Message formatting. Data bytes always carry bit7=0; status bytes bit7=1.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    status_byte = {4'hB, ev_chan};
    data1_byte  = {1'b0, ev_d1};
    data2_byte  = {1'b0, ev_d2};
    case (ev_type)
      EV_CC:   status_byte = {4'hB, ev_chan};
      EV_PB: begin
        status_byte = {4'hE, ev_chan};
        data1_byte  = {1'b0, pitch_val[6:0]};
        data2_byte  = {1'b0, pitch_val[13:7]};
      end
      EV_NON:  status_byte = {4'h9, ev_chan};
      EV_NOFF: status_byte = {4'h8, ev_chan};
      default: status_byte = {4'hB, ev_chan};
    endcase
  end

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;

  assign skip_status = (status_byte == last_status);

  // Updated at acceptance: a status byte that is not skipped is committed
  // to the wire. An abort by reset clears it, so nothing stale survives.
  always_ff @(posedge CLOCK_25) begin
    if (reset_data) begin
      last_status <= 8'h00;
    end else if (load && !skip_status) begin
      last_status <= status_byte;
    end
  end
`else
  assign skip_status = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Byte of the buffer that the next cycle will be shifting.
  // -------------------------------------------------------------------------
  always_comb begin
    cur_byte = msg[2];
    case (byte_n)
      2'd0:    cur_byte = msg[0];
      2'd1:    cur_byte = msg[1];
      default: cur_byte = msg[2];
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    busy_n  = busy;

    case (state)
      S_IDLE: begin
        if (ev_valid) begin
          state_n = S_START;
          timer_n = '0;
          bit_n   = 3'd0;
          // A skipped status byte simply starts the frame at byte 1.
          byte_n  = skip_status ? 2'd1 : 2'd0;
          busy_n  = 1'b1;
        end
      end

      S_START: begin
        if (bit_tick) begin
          timer_n = '0;
          bit_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          timer_n = '0;
          if (byte_idx == 2'd2) begin
            // Last stop bit ends on this edge: busy falls, ev_ready rises.
            state_n = S_IDLE;
            byte_n  = 2'd0;
            busy_n  = 1'b0;
          end else begin
            byte_n  = byte_idx + 2'd1;
            state_n = S_START;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        timer_n = '0;
        bit_n   = 3'd0;
        byte_n  = 2'd0;
        busy_n  = 1'b0;
      end
    endcase

    // midi_txd is registered from the next state so the line is glitch-free
    // and the start bit begins on the acceptance edge itself.
    txd_n = 1'b1;
    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = cur_byte[bit_n];
      default: txd_n = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK_25) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (reset_data) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      busy     <= 1'b0;
      midi_txd <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      busy     <= busy_n;
      midi_txd <= txd_n;
    end
  end

  // NOTE: the message buffer carries no reset; it is always written on
  // acceptance before any of its bits reach the line, so resetting it would
  // only add reset fan-out.
  always_ff @(posedge CLOCK_25) begin
    if (load) begin
      msg[0] <= status_byte;
      msg[1] <= data1_byte;
      msg[2] <= data2_byte;
    end
  end

endmodule

// File: tb/tb_midi_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_midi_tx_encoder
//
// Self-checking bench for midi_tx_encoder. Expected bytes are pushed into a
// scoreboard queue when an event is accepted; a serial monitor decodes each
// 8N1 byte on midi_txd, verifies every bit lasts exactly BIT_CLKS cycles and
// compares the byte against the queue head.
// The DUT clock parameter is scaled down so each bit is BIT_CLKS=32 clocks;
// every timing expectation below is written in terms of BIT_CLKS.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_tx_encoder;

  localparam int  CLK_HZ   = 1000000;
  localparam int  BAUD     = 31250;
  localparam int  BIT_CLKS = CLK_HZ / BAUD;
  localparam time PER      = 40;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit  RS_EN    = 1'b1;
`else
  localparam bit  RS_EN    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_data = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [1:0]  ev_type = 2'd0;
  logic [3:0]  ev_chan = 4'd0;
  logic [6:0]  ev_d1 = 7'd0;
  logic [6:0]  ev_d2 = 7'd0;
  logic [13:0] pitch_val = 14'd0;
  logic        midi_txd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_last = 8'h00;
  bit         mon_en = 1'b0;

  always #(PER/2) clk = ~clk;

  midi_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLOCK_25  (clk),
    .reset_data(reset_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_type   (ev_type),
    .ev_chan   (ev_chan),
    .ev_d1     (ev_d1),
    .ev_d2     (ev_d2),
    .pitch_val (pitch_val),
    .midi_txd  (midi_txd),
    .busy      (busy)
  );

  // -------------------------------------------------------------------------
  // Serial monitor: one byte per start bit, all samples on the falling edge.
  // -------------------------------------------------------------------------
  logic [9:0] mon_bits;
  bit         mon_stable;
  bit         mon_abort;
  logic [7:0] mon_exp;

  always begin : monitor
    @(negedge clk);
    if (mon_en && midi_txd === 1'b0) begin
      mon_stable = 1'b1;
      mon_abort  = 1'b0;
      mon_bits   = '0;
      for (int b = 0; b < 10 && !mon_abort; b++) begin
        for (int c = 0; c < BIT_CLKS && !mon_abort; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!mon_en) mon_abort = 1'b1;
          else if (c == 0) mon_bits[b] = midi_txd;
          else if (midi_txd !== mon_bits[b]) mon_stable = 1'b0;
        end
      end
      if (!mon_abort) begin
        checks++;
        if (!mon_stable || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
          errors++;
          $display("FAIL frame_timing: bits=%b stable=%0d, required start=0 stop=1 each bit %0d clocks",
                   mon_bits, mon_stable, BIT_CLKS);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_value: got unexpected byte %02h, required no byte", mon_bits[8:1]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_bits[8:1] !== mon_exp) begin
            errors++;
            $display("FAIL byte_value: got %02h, required %02h", mon_bits[8:1], mon_exp);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: bytes an accepted event should produce.
  // -------------------------------------------------------------------------
  task automatic push_expected(input logic [1:0] t, input logic [3:0] ch,
                               input logic [6:0] d1, input logic [6:0] d2,
                               input logic [13:0] pv);
    logic [7:0] st;
    logic [7:0] b1;
    logic [7:0] b2;
    case (t)
      2'd0:    st = 8'hB0 | {4'h0, ch};
      2'd1:    st = 8'hE0 | {4'h0, ch};
      2'd2:    st = 8'h90 | {4'h0, ch};
      default: st = 8'h80 | {4'h0, ch};
    endcase
    if (t == 2'd1) begin
      b1 = {1'b0, pv[6:0]};
      b2 = {1'b0, pv[13:7]};
    end else begin
      b1 = {1'b0, d1};
      b2 = {1'b0, d2};
    end
    if (!RS_EN || st != model_last) exp_q.push_back(st);
    model_last = st;
    exp_q.push_back(b1);
    exp_q.push_back(b2);
  endtask

  // Presents an event, waits for acceptance, then scrambles the fields so the
  // DUT must rely on what it captured. Returns the acceptance edge time.
  task automatic send_event(input logic [1:0] t, input logic [3:0] ch,
                            input logic [6:0] d1, input logic [6:0] d2,
                            input logic [13:0] pv, output time acc_t);
    bit ok = 1'b0;
    bit rdy;
    @(negedge clk);
    ev_type = t; ev_chan = ch; ev_d1 = d1; ev_d2 = d2; pitch_val = pv;
    ev_valid = 1'b1;
    for (int i = 0; i < 40 * BIT_CLKS && !ok; i++) begin
      rdy = ev_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      else @(negedge clk);
    end
    acc_t = $time;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: event type %0d never accepted", t);
    end else begin
      push_expected(t, ch, d1, d2, pv);
    end
    @(negedge clk);
    ev_valid  = 1'b0;
    ev_type   = 2'($urandom);
    ev_chan   = 4'($urandom);
    ev_d1     = 7'($urandom);
    ev_d2     = 7'($urandom);
    pitch_val = 14'($urandom);
  endtask

  // Counts busy cycles from the current falling edge; flags ev_ready while busy.
  task automatic measure_busy(input string name, input int expected);
    int  n = 0;
    bit  rdy_bad = 1'b0;
    while (busy === 1'b1 && n < 40 * BIT_CLKS) begin
      n++;
      if (ev_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (n != expected) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, n, expected);
    end
    checks++;
    if (rdy_bad) begin
      errors++;
      $display("FAIL %s_ready_while_busy: got ev_ready=1 during busy, required 0", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200 * BIT_CLKS) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes outstanding busy=%b, required 0 and 0",
               name, exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (midi_txd !== 1'b1 || busy !== 1'b0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got txd=%b busy=%b ready=%b, required 1 0 1",
               name, midi_txd, busy, ev_ready);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    int edges = 0;
    logic prev;
    reset_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_data = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
    prev = midi_txd;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (midi_txd !== prev) edges++;
      prev = midi_txd;
    end
    checks++;
    if (edges != 0) begin
      errors++;
      $display("FAIL reset_idle_edges: got %0d txd edges, required 0", edges);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_control_change();
    time t;
    send_event(2'd0, 4'd3, 7'd7, 7'd100, 14'd0, t);
    checks++;
    if (midi_txd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cc_first_edge: got txd=%b busy=%b one cycle after accept, required 0 1",
               midi_txd, busy);
    end
    measure_busy("cc", 30 * BIT_CLKS);
    wait_drain("cc");
  endtask

  task automatic test_pitch_bend();
    time t;
    send_event(2'd1, 4'd0, 7'd0, 7'd0, 14'h2000, t);
    measure_busy("pb_centre", 30 * BIT_CLKS);
    wait_drain("pb_centre");
    send_event(2'd1, 4'd0, 7'd0, 7'd0, 14'h3FFF, t);
    measure_busy("pb_max", (RS_EN ? 20 : 30) * BIT_CLKS);
    wait_drain("pb_max");
  endtask

  task automatic test_back_to_back();
    time t1;
    time t2;
    send_event(2'd2, 4'd15, 7'd60, 7'h7F, 14'd0, t1);
    send_event(2'd2, 4'd15, 7'd62, 7'h7F, 14'd0, t2);
    checks++;
    if (t2 - t1 != (30 * BIT_CLKS + 1) * PER) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0t, required %0t",
               t2 - t1, (30 * BIT_CLKS + 1) * PER);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_abort();
    time t;
    send_event(2'd0, 4'd3, 7'd1, 7'd2, 14'd0, t);
    repeat (5 * BIT_CLKS - 2) @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    reset_data = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_state");
    reset_data = 1'b0;
    exp_q.delete();
    model_last = 8'h00;
    @(negedge clk);
    check_idle_outputs("abort_release");
    mon_en = 1'b1;
    send_event(2'd0, 4'd3, 7'd1, 7'd2, 14'd0, t);
    measure_busy("after_abort", 30 * BIT_CLKS);
    wait_drain("after_abort");
  endtask

  task automatic test_capture();
    time t;
    send_event(2'd3, 4'd5, 7'h11, 7'h22, 14'h1234, t);
    wait_drain("capture");
  endtask

  task automatic test_random_stream();
    time t;
    for (int i = 0; i < 6; i++) begin
      send_event(2'($urandom_range(0, 3)), 4'($urandom_range(0, 1)),
                 7'($urandom), 7'($urandom), 14'($urandom), t);
    end
    wait_drain("random");
  endtask

  initial begin
    test_reset();
    test_control_change();
    test_pitch_bend();
    test_back_to_back();
    test_reset_abort();
    test_capture();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
